// File: rtl/immgen_pkg.sv
// ============================================================================
// Module      : immgen_pkg
// Description : Shared types and RV32I opcode constants for the immediate
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package immgen_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    I    = 3'd1,
    S    = 3'd2,
    B    = 3'd3,
    U    = 3'd4,
    J    = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

endpackage

`default_nettype wire

// File: rtl/immgen_decode.sv
// ============================================================================
// Module      : immgen_decode
// Description : Combinational opcode to immediate-format decode. Unknown-opcode
//               detection is compiled only when IMMGEN_ILLEGAL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module immgen_decode
  import immgen_pkg::*;
(
  input  logic [6:0] opcode_i,
  output imm_fmt_t   fmt_o,
  output logic       illegal_o
);

  always_comb begin
    fmt_o = NONE;
    case (opcode_i)
      OP_LOAD, OP_IMM, OP_JALR,
      OP_MISC_MEM, OP_SYSTEM: fmt_o = I;
      OP_STORE:               fmt_o = S;
      OP_BRANCH:              fmt_o = B;
      OP_LUI, OP_AUIPC:       fmt_o = U;
      OP_JAL:                 fmt_o = J;
      default:                fmt_o = NONE;
    endcase
  end

`ifdef IMMGEN_ILLEGAL_EN
  // Every listed opcode maps to a real format, so NONE means "not in the table".
  assign illegal_o = (fmt_o == NONE);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/immgen.sv
// ============================================================================
// Module      : immgen
// Description : RV32I immediate generator with combinational and registered
//               outputs. Optional macro: IMMGEN_ILLEGAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module immgen
  import immgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        en,
  output logic [31:0] imm,
  output imm_fmt_t    fmt,
  output logic [31:0] imm_q,
  output imm_fmt_t    fmt_q,
  output logic        illegal
);

  logic [31:0] imm_d;
  imm_fmt_t    fmt_d;
  logic        w_sign;

  immgen_decode u_decode (
    .opcode_i  (instr[6:0]),
    .fmt_o     (fmt),
    .illegal_o (illegal)
  );

  assign w_sign = instr[31];

  always_comb begin
    imm = 32'd0;
    case (fmt)
      I:       imm = {{20{w_sign}}, instr[31:20]};
      S:       imm = {{20{w_sign}}, instr[31:25], instr[11:7]};
      B:       imm = {{19{w_sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      U:       imm = {instr[31:12], 12'd0};
      J:       imm = {{11{w_sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  always_comb begin
    imm_d = imm_q;
    fmt_d = fmt_q;
    if (en) begin
      imm_d = imm;
      fmt_d = fmt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q <= 32'd0;
      fmt_q <= NONE;
    end else begin
      imm_q <= imm_d;
      fmt_q <= fmt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_immgen.sv
// ============================================================================
// Module      : tb_immgen
// Description : Scoreboard bench for immgen: combinational decode, register
//               path, asynchronous reset and unknown opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_immgen;
  import immgen_pkg::*;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        en;
  logic [31:0] imm;
  imm_fmt_t    fmt;
  logic [31:0] imm_q;
  imm_fmt_t    fmt_q;
  logic        illegal;

  exp_t        sb_q[$];
  exp_t        last_ld;
  int          n_cmp;
  int          n_err;

  immgen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .instr   (instr),
    .en      (en),
    .imm     (imm),
    .fmt     (fmt),
    .imm_q   (imm_q),
    .fmt_q   (fmt_q),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model written straight from the bit-assembly table.
  function automatic exp_t model(input logic [31:0] x);
    exp_t e;
    logic s;
    s     = x[31];
    e.imm = 32'd0;
    e.fmt = 3'd0;
    case (x[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
        e.fmt = 3'd1;
        e.imm = {{20{s}}, x[31:20]};
      end
      7'h23: begin
        e.fmt = 3'd2;
        e.imm = {{20{s}}, x[31:25], x[11:7]};
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = {{20{s}}, x[7], x[30:25], x[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        e.imm = {x[31:12], 12'd0};
      end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = {{12{s}}, x[19:12], x[20], x[30:21], 1'b0};
      end
      default: ;
    endcase
`ifdef IMMGEN_ILLEGAL_EN
    e.ill = (e.fmt == 3'd0);
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic comb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_imm"}, imm, e.imm);
      chk({tag, "_fmt"}, 32'(fmt), 32'(e.fmt));
      chk({tag, "_ill"}, 32'(illegal), 32'(e.ill));
    end
  endtask

  task automatic reg_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_imm_q"}, imm_q, e.imm);
      chk({tag, "_fmt_q"}, 32'(fmt_q), 32'(e.fmt));
    end
  endtask

  task automatic comb_vec(input string tag, input logic [31:0] x, input exp_t e);
    instr = x;
    sb_q.push_back(e);
    #1;
    comb_check(tag);
  endtask

  task automatic load(input string tag, input logic [31:0] x);
    @(negedge clk);
    instr = x;
    en    = 1'b1;
    last_ld = model(x);
    sb_q.push_back(last_ld);
    @(posedge clk);
    #1;
    reg_check(tag);
  endtask

  logic [6:0]  ops [11];
  logic [31:0] rnd;
  exp_t        tv;

  initial begin
    n_cmp = 0;
    n_err = 0;
    ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    rst_n = 1'b0;
    en    = 1'b0;
    instr = 32'd0;
    #12;
    chk("rst_imm_q", imm_q, 32'd0);
    chk("rst_fmt_q", 32'(fmt_q), 32'(NONE));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations.
    tv = '{imm: 32'hFFFFFFFF, fmt: 3'd1, ill: 1'b0}; comb_vec("lw",  32'hFFF02003, tv);
    tv = '{imm: 32'hFFFFFFFE, fmt: 3'd2, ill: 1'b0}; comb_vec("sw",  32'hFE102F23, tv);
    tv = '{imm: 32'hFFFFFF0E, fmt: 3'd3, ill: 1'b0}; comb_vec("beq", 32'hF00007E3, tv);
    tv = '{imm: 32'h12345000, fmt: 3'd4, ill: 1'b0}; comb_vec("lui", 32'h123450B7, tv);
    tv = '{imm: 32'hFFFFFFFE, fmt: 3'd5, ill: 1'b0}; comb_vec("jal", 32'hFFFFF06F, tv);
`ifdef IMMGEN_ILLEGAL_EN
    tv = '{imm: 32'h0, fmt: 3'd0, ill: 1'b1};
`else
    tv = '{imm: 32'h0, fmt: 3'd0, ill: 1'b0};
`endif
    comb_vec("unk", 32'h0000007F, tv);
    tv = '{imm: 32'h000007FF, fmt: 3'd1, ill: 1'b0}; comb_vec("addi_pos", 32'h7FF00013, tv);
    tv = '{imm: 32'h00000FFE, fmt: 3'd3, ill: 1'b0}; comb_vec("b_pos",    32'h7E000FE3, tv);

    for (int k = 0; k < 60; k++) begin
      rnd = $urandom();
      if (k % 4 == 3) rnd[6:0] = 7'($urandom_range(0, 127));
      else            rnd[6:0] = ops[$urandom_range(0, 10)];
      comb_vec("rnd", rnd, model(rnd));
    end

    // Register path: load, hold, reset mid-cycle, reload.
    load("ld_lw", 32'hFFF02003);
    load("ld_jal", 32'hFFFFF06F);
    @(negedge clk);
    en    = 1'b0;
    instr = 32'h123450B7;
    sb_q.push_back(last_ld);
    @(posedge clk);
    #1;
    reg_check("hold");
    load("ld_sw", 32'hFE102F23);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_imm_q", imm_q, 32'd0);
    chk("arst_fmt_q", 32'(fmt_q), 32'(NONE));
    chk("arst_comb_imm", imm, 32'hFFFFFFFE);
    @(negedge clk);
    rst_n = 1'b1;
    load("post_rst_lui", 32'h123450B7);
    load("ld_unk", 32'h0000007F);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
